// File: rtl/seq_div_param_if.sv
// Operand/result bundle for seq_div_param.
//   start, data                                      : requester -> divider
//   quotient, remainder, div_by_zero, busy, done     : divider -> requester
interface seq_div_param_if #(
  parameter int unsigned WIDTH = 8
);
  logic             start;
  logic [WIDTH-1:0] data;
  logic [WIDTH-1:0] quotient;
  logic [WIDTH-1:0] remainder;
  logic             div_by_zero;
  logic             busy;
  logic             done;

  // Requester side: drives the request and operands, observes results.
  modport master (
    output start, data,
    input  quotient, remainder, div_by_zero, busy, done
  );

  // Divider side.
  modport slave (
    input  start, data,
    output quotient, remainder, div_by_zero, busy, done
  );
endinterface

// File: rtl/seq_div_param.sv
// Parametrised restoring shift-subtract divider, one quotient bit per cycle.
// Operands arrive over a shared bus: dividend with start, divisor next cycle.
// Ports:
//   clk  : rising-edge clock
//   rst  : asynchronous active-high reset
//   bus  : seq_div_param_if.slave (start, data in; quotient, remainder,
//          div_by_zero, busy, done out, all registered)
module seq_div_param #(
  parameter int unsigned WIDTH  = 8,
  parameter int unsigned SIGNED = 0
) (
  input  logic           clk,
  input  logic           rst,
  seq_div_param_if.slave bus
);

  localparam int unsigned CNT_W     = $clog2(WIDTH);
  localparam bit          IS_SIGNED = (SIGNED != 0);
  localparam logic [WIDTH-1:0] ONE  = WIDTH'(1);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(WIDTH - 1);

  typedef enum logic [2:0] {
    IDLE,
    LOAD_B,
    CHECK,
    RUN,
    FIXUP,
    DONE
  } state_e;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] a_raw_q, a_raw_d;   // dividend exactly as loaded
  logic [WIDTH-1:0] a_q, a_d;           // dividend magnitude, shifts into quotient
  logic [WIDTH-1:0] b_q, b_d;           // divisor magnitude
  logic [WIDTH-1:0] rem_q, rem_d;       // partial remainder (always < divisor)
  logic             sa_q, sa_d;
  logic             sb_q, sb_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] quotient_q, quotient_d;
  logic [WIDTH-1:0] remainder_q, remainder_d;
  logic             dbz_q, dbz_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;

  logic [WIDTH:0]   shifted;
  logic [WIDTH:0]   diff;

  // Conditional two's-complement negate; -min wraps to min, which as an
  // unsigned magnitude is exactly 2^(WIDTH-1).
  function automatic logic [WIDTH-1:0] neg_if(input logic [WIDTH-1:0] v,
                                              input logic             neg);
    return neg ? (~v + ONE) : v;
  endfunction

  // State and datapath registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      a_raw_q     <= '0;
      a_q         <= '0;
      b_q         <= '0;
      rem_q       <= '0;
      sa_q        <= 1'b0;
      sb_q        <= 1'b0;
      cnt_q       <= '0;
      quotient_q  <= '0;
      remainder_q <= '0;
      dbz_q       <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      a_raw_q     <= a_raw_d;
      a_q         <= a_d;
      b_q         <= b_d;
      rem_q       <= rem_d;
      sa_q        <= sa_d;
      sb_q        <= sb_d;
      cnt_q       <= cnt_d;
      quotient_q  <= quotient_d;
      remainder_q <= remainder_d;
      dbz_q       <= dbz_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
    end
  end

  // Next-state, datapath and registered-output logic.
  always_comb begin
    state_d     = state_q;
    a_raw_d     = a_raw_q;
    a_d         = a_q;
    b_d         = b_q;
    rem_d       = rem_q;
    sa_d        = sa_q;
    sb_d        = sb_q;
    cnt_d       = cnt_q;
    quotient_d  = quotient_q;
    remainder_d = remainder_q;
    dbz_d       = dbz_q;
    busy_d      = busy_q;
    done_d      = 1'b0;

    // Trial subtraction on the WIDTH+1-bit shifted partial remainder.
    shifted = {rem_q, a_q[WIDTH-1]};
    diff    = shifted - {1'b0, b_q};

    unique case (state_q)
      IDLE: begin
        if (bus.start) begin
          a_raw_d = bus.data;
          sa_d    = IS_SIGNED && bus.data[WIDTH-1];
          a_d     = neg_if(bus.data, IS_SIGNED && bus.data[WIDTH-1]);
          busy_d  = 1'b1;
          state_d = LOAD_B;
        end
      end

      LOAD_B: begin
        sb_d    = IS_SIGNED && bus.data[WIDTH-1];
        b_d     = neg_if(bus.data, IS_SIGNED && bus.data[WIDTH-1]);
        state_d = CHECK;
      end

      CHECK: begin
        if (b_q == '0) begin
          quotient_d  = '1;
          remainder_d = a_raw_q;
          dbz_d       = 1'b1;
          busy_d      = 1'b0;
          done_d      = 1'b1;
          state_d     = DONE;
        end else begin
          rem_d   = '0;
          cnt_d   = '0;
          state_d = RUN;
        end
      end

      RUN: begin
        // diff MSB clear means the trial result is non-negative.
        if (!diff[WIDTH]) begin
          rem_d = diff[WIDTH-1:0];
          a_d   = {a_q[WIDTH-2:0], 1'b1};
        end else begin
          rem_d = shifted[WIDTH-1:0];
          a_d   = {a_q[WIDTH-2:0], 1'b0};
        end
        cnt_d = cnt_q + CNT_W'(1);
        if (cnt_q == LAST) begin
          state_d = FIXUP;
        end
      end

      FIXUP: begin
        // Sign flags are always 0 in unsigned mode, making this a pass-through.
        quotient_d  = neg_if(a_q, sa_q ^ sb_q);
        remainder_d = neg_if(rem_q, sa_q);
        dbz_d       = 1'b0;
        busy_d      = 1'b0;
        done_d      = 1'b1;
        state_d     = DONE;
      end

      DONE: begin
        state_d = IDLE;
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  assign bus.quotient    = quotient_q;
  assign bus.remainder   = remainder_q;
  assign bus.div_by_zero = dbz_q;
  assign bus.busy        = busy_q;
  assign bus.done        = done_q;

endmodule

// File: tb/tb_seq_div_param.sv
// Scoreboard bench for seq_div_param: 8-bit unsigned and 8-bit signed
// instances share one operand stream; a 16-bit unsigned instance runs alone.
module tb_seq_div_param;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic        start8  = 1'b0;
  logic [7:0]  data8   = '0;
  logic        start16 = 1'b0;
  logic [15:0] data16  = '0;

  seq_div_param_if #(.WIDTH(8))  if_u8 ();
  seq_div_param_if #(.WIDTH(8))  if_s8 ();
  seq_div_param_if #(.WIDTH(16)) if_w16 ();

  assign if_u8.start  = start8;
  assign if_u8.data   = data8;
  assign if_s8.start  = start8;
  assign if_s8.data   = data8;
  assign if_w16.start = start16;
  assign if_w16.data  = data16;

  seq_div_param #(.WIDTH(8), .SIGNED(0)) u_u8 (
    .clk (clk), .rst (rst), .bus (if_u8)
  );
  seq_div_param #(.WIDTH(8), .SIGNED(1)) u_s8 (
    .clk (clk), .rst (rst), .bus (if_s8)
  );
  seq_div_param #(.WIDTH(16), .SIGNED(0)) u_w16 (
    .clk (clk), .rst (rst), .bus (if_w16)
  );

  typedef struct {
    logic [15:0] q;
    logic [15:0] r;
    logic        dbz;
    int          cyc;
  } exp_t;

  exp_t sb_u8[$];
  exp_t sb_s8[$];
  exp_t sb_w16[$];

  int n_chk  = 0;
  int n_pass = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h) at cycle %0d",
                  name, act, act, exp, exp, cyc);
  endtask

  task automatic fail_now(input string name);
    n_chk++;
    $display("FAIL %s at cycle %0d", name, cyc);
  endtask

  // Monitors: pop and compare whenever a DUT presents done.
  exp_t e_u8, e_s8, e_w16;

  always @(negedge clk) begin
    if (!rst && if_u8.done) begin
      if (sb_u8.size() == 0) fail_now("u8_unexpected_done");
      else begin
        e_u8 = sb_u8.pop_front();
        chk("u8_quotient",  32'(if_u8.quotient),    32'(e_u8.q));
        chk("u8_remainder", 32'(if_u8.remainder),   32'(e_u8.r));
        chk("u8_dbz",       32'(if_u8.div_by_zero), 32'(e_u8.dbz));
        chk("u8_latency",   32'(cyc),               32'(e_u8.cyc));
        chk("u8_busy_low_in_done", 32'(if_u8.busy), 32'd0);
      end
    end
  end

  always @(negedge clk) begin
    if (!rst && if_s8.done) begin
      if (sb_s8.size() == 0) fail_now("s8_unexpected_done");
      else begin
        e_s8 = sb_s8.pop_front();
        chk("s8_quotient",  32'(if_s8.quotient),    32'(e_s8.q));
        chk("s8_remainder", 32'(if_s8.remainder),   32'(e_s8.r));
        chk("s8_dbz",       32'(if_s8.div_by_zero), 32'(e_s8.dbz));
        chk("s8_latency",   32'(cyc),               32'(e_s8.cyc));
      end
    end
  end

  always @(negedge clk) begin
    if (!rst && if_w16.done) begin
      if (sb_w16.size() == 0) fail_now("w16_unexpected_done");
      else begin
        e_w16 = sb_w16.pop_front();
        chk("w16_quotient",  32'(if_w16.quotient),    32'(e_w16.q));
        chk("w16_remainder", 32'(if_w16.remainder),   32'(e_w16.r));
        chk("w16_dbz",       32'(if_w16.div_by_zero), 32'(e_w16.dbz));
        chk("w16_latency",   32'(cyc),                32'(e_w16.cyc));
      end
    end
  end

  // mode 0: plain op; 1: extra start pulse during RUN; 2: reset mid-RUN.
  task automatic op8(input logic [7:0] a, input logic [7:0] b,
                     input logic [7:0] qu, input logic [7:0] ru,
                     input logic [7:0] qs, input logic [7:0] rs,
                     input logic dbz, input int mode);
    int   e0;
    exp_t eu, es;
    @(negedge clk);
    start8 = 1'b1;
    data8  = a;
    @(posedge clk);
    #1;
    e0 = cyc;
    if (mode != 2) begin
      eu.q = 16'(qu); eu.r = 16'(ru); eu.dbz = dbz; eu.cyc = e0 + (dbz ? 2 : 11);
      es.q = 16'(qs); es.r = 16'(rs); es.dbz = dbz; es.cyc = eu.cyc;
      sb_u8.push_back(eu);
      sb_s8.push_back(es);
    end
    @(negedge clk);
    start8 = 1'b0;
    data8  = b;
    chk("u8_busy_after_start", 32'(if_u8.busy), 32'd1);
    @(negedge clk);
    data8 = 8'hA5;
    if (mode == 1) begin
      repeat (3) @(negedge clk);
      start8 = 1'b1;
      data8  = 8'd5;
      @(negedge clk);
      start8 = 1'b0;
      data8  = 8'd3;
      @(negedge clk);
      data8  = 8'hA5;
    end
    if (mode == 2) begin
      repeat (3) @(negedge clk);
      #1 rst = 1'b1;
      #1;
      chk("rst_u8_quotient",  32'(if_u8.quotient),  32'd0);
      chk("rst_u8_remainder", 32'(if_u8.remainder), 32'd0);
      chk("rst_u8_busy",      32'(if_u8.busy),      32'd0);
      chk("rst_s8_quotient",  32'(if_s8.quotient),  32'd0);
      chk("rst_s8_busy",      32'(if_s8.busy),      32'd0);
      @(negedge clk);
      rst = 1'b0;
      // Monitors flag any done from the discarded operation.
      repeat (20) @(negedge clk);
      chk("rst_u8_idle_after", 32'(if_u8.busy), 32'd0);
    end else begin
      for (int i = 0; i < 40 && !if_u8.done; i++) @(negedge clk);
      if (!if_u8.done) fail_now("u8_done_timeout");
      else begin
        @(negedge clk);
        chk("u8_done_single_pulse", 32'(if_u8.done), 32'd0);
      end
    end
  endtask

  task automatic op16(input logic [15:0] a, input logic [15:0] b,
                      input logic [15:0] q, input logic [15:0] r, input logic dbz);
    exp_t e;
    @(negedge clk);
    start16 = 1'b1;
    data16  = a;
    @(posedge clk);
    #1;
    e.q = q; e.r = r; e.dbz = dbz; e.cyc = cyc + (dbz ? 2 : 19);
    sb_w16.push_back(e);
    @(negedge clk);
    start16 = 1'b0;
    data16  = b;
    chk("w16_busy_after_start", 32'(if_w16.busy), 32'd1);
    @(negedge clk);
    data16 = 16'hA5A5;
    for (int i = 0; i < 60 && !if_w16.done; i++) @(negedge clk);
    if (!if_w16.done) fail_now("w16_done_timeout");
    else @(negedge clk);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog_timeout at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("reset_u8_quotient",  32'(if_u8.quotient),     32'd0);
    chk("reset_u8_remainder", 32'(if_u8.remainder),    32'd0);
    chk("reset_u8_dbz",       32'(if_u8.div_by_zero),  32'd0);
    chk("reset_u8_busy",      32'(if_u8.busy),         32'd0);
    chk("reset_u8_done",      32'(if_u8.done),         32'd0);
    chk("reset_w16_quotient", 32'(if_w16.quotient),    32'd0);

    //    a      b      q_u    r_u    q_s    r_s    dbz  mode
    op8(8'd100, 8'd23, 8'd4,   8'd8,   8'd4,   8'd8,   1'b0, 0);
    op8(8'd255, 8'd1,  8'd255, 8'd0,   8'hFF,  8'd0,   1'b0, 0);
    op8(8'd7,   8'd9,  8'd0,   8'd7,   8'd0,   8'd7,   1'b0, 0);
    op8(8'd200, 8'd0,  8'hFF,  8'd200, 8'hFF,  8'hC8,  1'b1, 0);
    op8(8'hF9,  8'd2,  8'd124, 8'd1,   8'hFD,  8'hFF,  1'b0, 0);
    op8(8'd7,   8'hFE, 8'd0,   8'd7,   8'hFD,  8'd1,   1'b0, 0);
    op8(8'h80,  8'hFF, 8'd0,   8'd128, 8'h80,  8'd0,   1'b0, 0);
    op8(8'd100, 8'd23, 8'd4,   8'd8,   8'd4,   8'd8,   1'b0, 1);
    op8(8'd100, 8'd23, 8'd0,   8'd0,   8'd0,   8'd0,   1'b0, 2);
    op8(8'd100, 8'd23, 8'd4,   8'd8,   8'd4,   8'd8,   1'b0, 0);

    op16(16'd50000, 16'd7,   16'd7142, 16'd6,   1'b0);
    op16(16'd65535, 16'd256, 16'd255,  16'd255, 1'b0);
    op16(16'd1234,  16'd0,   16'hFFFF, 16'd1234, 1'b1);

    repeat (5) @(negedge clk);
    chk("sb_u8_drained",  32'(sb_u8.size()),  32'd0);
    chk("sb_s8_drained",  32'(sb_s8.size()),  32'd0);
    chk("sb_w16_drained", 32'(sb_w16.size()), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/seq_div_param.md
# seq_div_param

Parametrised multi-cycle integer divider, the next generation of the 8-bit repeated-subtraction divider. Operands arrive over a single shared `data` bus on two consecutive cycles (dividend, then divisor), exactly as in the earlier divider. A restoring shift-subtract core produces one quotient bit per cycle, so latency is fixed and independent of operand values. Adds width/sign parametrisation, a `busy`/`done` handshake, divide-by-zero detection and reset.

## Interface
- `WIDTH`, 8: operand, quotient and remainder width; legal range ≥ 2.
- `SIGNED`, 0: 0 = unsigned operands; 1 = two's-complement operands with truncating division.
- `clk`  in  1  clock; all state changes on the rising edge.
- `rst`  in  1  reset, asynchronous, active-high.
- `start`  in  1  request; sampled only in IDLE; `data` holds the dividend in the same cycle.
- `data`  in  WIDTH  shared operand bus: dividend in the start cycle, divisor in the next cycle.
- `quotient`  out  WIDTH  registered result.
- `remainder`  out  WIDTH  registered result.
- `div_by_zero`  out  1  registered flag for the most recent operation.
- `busy`  out  1  operation in progress.
- `done`  out  1  one-cycle completion pulse.

## Operation
- **States:** IDLE, LOAD_B, CHECK, RUN, FIXUP, DONE.
- **IDLE:**
  - On `start`=1, capture `data` as the dividend and go to LOAD_B.
  - In SIGNED mode, store the magnitude and the sign bit of the dividend.
- **LOAD_B:** capture `data` as the divisor (magnitude and sign as above), then go to CHECK.
- **CHECK:**
  - Divisor == 0: go to DONE.
    - `quotient` = all ones.
    - `remainder` = dividend as loaded (signed value when SIGNED=1).
    - `div_by_zero` = 1.
  - Otherwise: clear the partial remainder, set the bit counter to 0 and go to RUN.
- **RUN** (one iteration per cycle, exactly WIDTH iterations):
  - Shift {partial remainder, dividend} left by 1.
  - Trial-subtract the divisor from the upper WIDTH+1 bits.
  - If the result is non-negative, keep it and shift in quotient bit 1; otherwise restore and shift in 0.
  - After iteration WIDTH-1, go to FIXUP.
- **FIXUP:**
  - SIGNED=1: negate the quotient if the operand signs differ; the remainder takes the dividend's sign.
  - SIGNED=0: pass-through.
  - In both modes, register `quotient`, `remainder` and `div_by_zero`=0, then go to DONE.
- **DONE:** `done`=1 for this single cycle, then return to IDLE.
- **Arithmetic widths:**
  - The partial remainder is WIDTH+1 bits wide.
  - Magnitudes are WIDTH-bit unsigned. |−2^(WIDTH−1)| = 2^(WIDTH−1) is representable unsigned.
  - Hence min ÷ −1 yields quotient = min (wraps) and remainder = 0, with no special case.
- **Result holding:** `quotient`, `remainder` and `div_by_zero` change only on entry to DONE. They hold their values through IDLE until the next completion.
- **`start` outside IDLE** is ignored; this includes a `start` during the DONE cycle.
- **`rst` asserted at any time:**
  - Immediately force IDLE.
  - All outputs return to 0.
  - Any in-flight operation is discarded; no `done` pulse is produced for it.

## Timing
- **Reset values:** `quotient`=0, `remainder`=0, `div_by_zero`=0, `busy`=0, `done`=0; state = IDLE.
- **Edge numbering:** E0 is the rising edge at which `start` is accepted.
  - E1 captures the divisor.
  - E2 leaves CHECK.
  - E3..E(WIDTH+2) perform the WIDTH RUN iterations.
  - E(WIDTH+3) leaves FIXUP.
- **Normal latency:** `done` is high between E(WIDTH+3) and E(WIDTH+4), with results valid in that same cycle. For WIDTH=8 this is after E11.
- **Divide-by-zero latency:** `done` is high between E2 and E3.
- **`busy`:** high from after E0 until the edge that enters DONE. It is low during DONE and during IDLE.
- **Back-to-back operation:** the earliest next `start` is the first IDLE cycle, i.e. one cycle after `done`.

## Test plan
- **Unsigned divide:** WIDTH=8, SIGNED=0; `data`=100 at the start cycle, 23 next cycle -> `quotient`=4, `remainder`=8, `div_by_zero`=0, `done` one cycle after E11, `busy` high E0..E10.
- **Unsigned corner cases:** WIDTH=8, SIGNED=0.
  - 255/1 -> q=255, r=0.
  - 7/9 -> q=0, r=7.
  - 200/0 -> q=255, r=200, `div_by_zero`=1, `done` after E2.
- **Signed truncation:** WIDTH=8, SIGNED=1.
  - −7/2 -> q=−3 (0xFD), r=−1 (0xFF).
  - 7/−2 -> q=−3, r=1.
  - −128/−1 -> q=−128 (0x80), r=0.
- **Wide unsigned:** WIDTH=16, SIGNED=0; 50000/7 -> q=7142, r=6; `done` after E19.
- **Handshake and reset:**
  - `start` pulsed again during RUN -> ignored; the result of the first operation is unchanged.
  - `rst` pulsed mid-RUN, asynchronously between edges -> outputs 0 immediately, no `done`.
  - A subsequent 100/23 then completes correctly.
